// File: rtl/arc4_enc.sv
// arc4_enc: ARC4 encryption of a length-prefixed plaintext memory into a ciphertext memory
module arc4_enc (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        rdy,
  input  logic [23:0] key,
  output logic [7:0]  pt_addr,
  input  logic [7:0]  pt_rddata,
  output logic [7:0]  ct_addr,
  output logic [7:0]  ct_wrdata,
  output logic        ct_wren
);
  typedef enum logic [2:0] {IDLE, INIT, KSA, RDLEN, WRLEN, PRGA} state_t;
  state_t state, state_nx;
  logic [7:0] s [256];
  logic [7:0] i, j, len, i_nx, j_nx, kb, ps, pad;
  logic [23:0] key_q;
  logic [1:0] m;
  logic ph;
  // index/sum arithmetic; ph splits RDLEN and each PRGA byte into read and write cycles
  always_comb begin
    kb = m == 2'd0 ? key_q[23:16] : m == 2'd1 ? key_q[15:8] : key_q[7:0];
    i_nx = state == PRGA ? i + 8'd1 : i;
    j_nx = j + s[i_nx] + (state == KSA ? kb : 8'd0);
    ps = s[i] + s[j];
    pad = s[ps];
  end
  // next state and memory-port outputs
  always_comb begin
    state_nx = state;
    rdy = 1'b0;
    pt_addr = 8'd0;
    ct_addr = 8'd0;
    ct_wrdata = 8'd0;
    ct_wren = 1'b0;
    case (state)
      IDLE: begin
        rdy = 1'b1;
        state_nx = en ? INIT : IDLE;
      end
      INIT: state_nx = i == 8'd255 ? KSA : INIT;
      KSA: state_nx = i == 8'd255 ? RDLEN : KSA;
      RDLEN: state_nx = ph ? WRLEN : RDLEN;
      WRLEN: begin
        ct_wrdata = len;
        ct_wren = 1'b1;
        state_nx = len == 8'd0 ? IDLE : PRGA;
      end
      PRGA: begin
        pt_addr = ph ? i : i_nx;
        ct_addr = i;
        ct_wrdata = pad ^ pt_rddata;
        ct_wren = ph;
        state_nx = ph && i == len ? IDLE : PRGA;
      end
      default: state_nx = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk) state <= !rst_n ? IDLE : state_nx;
  // S array, indices, key latch and length capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i <= 8'd0;
      j <= 8'd0;
      ph <= 1'b0;
      m <= 2'd0;
      len <= 8'd0;
      key_q <= 24'd0;
    end else begin
      case (state)
        IDLE: begin
          i <= 8'd0;
          j <= 8'd0;
          ph <= 1'b0;
          m <= 2'd0;
          if (en) key_q <= key;
        end
        INIT: begin
          s[i] <= i;
          i <= i + 8'd1;
        end
        KSA: begin
          s[i] <= s[j_nx];
          s[j_nx] <= s[i];
          j <= j_nx;
          i <= i + 8'd1;
          m <= m == 2'd2 ? 2'd0 : m + 2'd1;
        end
        RDLEN: begin
          ph <= ~ph;
          len <= pt_rddata;
        end
        WRLEN: begin
          i <= 8'd0;
          j <= 8'd0;
        end
        PRGA: begin
          ph <= ~ph;
          if (!ph) begin
            s[i_nx] <= s[j_nx];
            s[j_nx] <= s[i_nx];
            i <= i_nx;
            j <= j_nx;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_arc4_enc.sv
// tb_arc4_enc: table-driven scoreboard bench for arc4_enc
module tb_arc4_enc;
  logic clk = 1'b0;
  logic rst_n, en, rdy, ct_wren;
  logic [23:0] key;
  logic [7:0] pt_addr, pt_rddata, ct_addr, ct_wrdata;
  logic [7:0] pt_mem [256];
  logic [15:0] q [$];
  int ncmp = 0, nfail = 0, wr_cnt = 0, cur_len = 0;

  typedef struct {
    logic [23:0] key;
    int len;
    logic [71:0] pt;
    logic [71:0] ct;
    bit known;
    bit noisy;
  } vec_t;
  vec_t tbl [7];

  arc4_enc dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .key(key),
    .pt_addr(pt_addr), .pt_rddata(pt_rddata),
    .ct_addr(ct_addr), .ct_wrdata(ct_wrdata), .ct_wren(ct_wren)
  );

  always #5 clk = ~clk;
  always @(posedge clk) pt_rddata <= pt_mem[pt_addr];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, required %0h", nm, got, exp);
    end
  endtask

  task automatic push_model(input logic [23:0] k, input int n);
    logic [7:0] sb [256];
    logic [7:0] t, ii, jj, kk;
    for (int x = 0; x < 256; x++) sb[x] = x[7:0];
    jj = 8'd0;
    for (int x = 0; x < 256; x++) begin
      kk = (x % 3 == 0) ? k[23:16] : (x % 3 == 1) ? k[15:8] : k[7:0];
      jj = jj + sb[x] + kk;
      t = sb[x]; sb[x] = sb[jj]; sb[jj] = t;
    end
    q.push_back({8'd0, n[7:0]});
    ii = 8'd0;
    jj = 8'd0;
    for (int x = 1; x <= n; x++) begin
      ii = ii + 8'd1;
      jj = jj + sb[ii];
      t = sb[ii]; sb[ii] = sb[jj]; sb[jj] = t;
      t = sb[ii] + sb[jj];
      q.push_back({x[7:0], sb[t] ^ pt_mem[x]});
    end
  endtask

  task automatic load(input vec_t v);
    cur_len = v.len;
    pt_mem[0] = v.len[7:0];
    for (int x = 1; x <= v.len; x++)
      pt_mem[x] = v.known ? v.pt[8*(9-x) +: 8] : 8'($urandom);
    if (v.known) begin
      q.push_back({8'd0, v.len[7:0]});
      for (int x = 1; x <= v.len; x++) q.push_back({x[7:0], v.ct[8*(9-x) +: 8]});
    end else push_model(v.key, v.len);
  endtask

  task automatic run_op(input string nm, input vec_t v);
    int base, cyc;
    load(v);
    base = wr_cnt;
    en = 1'b1;
    key = v.key;
    @(negedge clk);
    en = 1'b0;
    key = 24'($urandom);
    chk({nm, "_busy"}, rdy, 1'b0);
    cyc = 0;
    while (!rdy && cyc < 3000) begin
      en = v.noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      key = 24'($urandom);
      @(negedge clk);
      cyc++;
    end
    en = 1'b0;
    chk({nm, "_done"}, rdy, 1'b1);
    chk({nm, "_queue_empty"}, q.size(), 0);
    chk({nm, "_write_count"}, wr_cnt - base, v.len + 1);
  endtask

  initial begin
    int base, cyc;
    tbl[0] = '{24'h4B6579, 9, 72'h506C61696E74657874, 72'hBBF316E8D940AF0AD3, 1'b1, 1'b0};
    tbl[1] = '{24'h000000, 0, 72'h0, 72'h0, 1'b1, 1'b0};
    tbl[2] = '{24'h4B6579, 9, 72'hBBF316E8D940AF0AD3, 72'h506C61696E74657874, 1'b1, 1'b1};
    tbl[3] = '{24'($urandom), 17, 72'h0, 72'h0, 1'b0, 1'b1};
    tbl[4] = '{24'h010203, 1, 72'h0, 72'h0, 1'b0, 1'b0};
    tbl[5] = '{24'($urandom), 255, 72'h0, 72'h0, 1'b0, 1'b0};
    tbl[6] = '{24'hFFFFFF, 9, 72'h0, 72'h0, 1'b0, 1'b1};
    for (int x = 0; x < 256; x++) pt_mem[x] = 8'd0;
    rst_n = 1'b0;
    en = 1'b1;
    key = 24'hABCDEF;
    fork
      forever begin
        @(negedge clk);
        if (pt_addr > cur_len) begin
          nfail++;
          $display("FAIL pt_range: got pt_addr %0d, required <= %0d", pt_addr, cur_len);
        end
        if (ct_wren) begin
          wr_cnt++;
          ncmp++;
          if (q.size() == 0) begin
            nfail++;
            $display("FAIL extra_write: got addr %0d data %02h, required no write", ct_addr, ct_wrdata);
          end else begin
            logic [15:0] e;
            e = q.pop_front();
            if ({ct_addr, ct_wrdata} !== e) begin
              nfail++;
              $display("FAIL ct_write: got addr %0d data %02h, required addr %0d data %02h",
                       ct_addr, ct_wrdata, e[15:8], e[7:0]);
            end
          end
        end
      end
    join_none
    repeat (4) begin
      @(negedge clk);
      chk("reset_en_held_rdy", rdy, 1'b1);
    end
    rst_n = 1'b1;
    en = 1'b0;
    chk("reset_ct_wren", ct_wren, 1'b0);
    chk("reset_ct_addr", ct_addr, 8'd0);
    chk("reset_ct_wrdata", ct_wrdata, 8'd0);
    chk("reset_pt_addr", pt_addr, 8'd0);
    @(negedge clk);
    chk("no_start_from_reset", rdy, 1'b1);
    for (int t = 0; t < 7; t++) run_op($sformatf("vec%0d", t), tbl[t]);
    load(tbl[0]);
    base = wr_cnt;
    en = 1'b1;
    key = tbl[0].key;
    @(negedge clk);
    en = 1'b0;
    cyc = 0;
    while (wr_cnt - base < 4 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk("midreset_reached_prga", wr_cnt - base >= 4, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    chk("midreset_rdy", rdy, 1'b1);
    chk("midreset_ct_wren", ct_wren, 1'b0);
    base = wr_cnt;
    repeat (20) @(negedge clk);
    chk("midreset_no_writes", wr_cnt - base, 0);
    run_op("rerun_kat", tbl[0]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
